// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath widths, fetch FSM states, program bound.
package cpu_pkg;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned INSTR_W   = 8;
  localparam int unsigned LAST_ADDR = 11;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } fetch_state_t;

endpackage : cpu_pkg

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives instruction memory and hands
// fetched words to decode over a valid/ready handshake with redirect/flush.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned P_ADDR_W    = ADDR_W,
  parameter int unsigned P_INSTR_W   = INSTR_W,
  parameter int unsigned P_LAST_ADDR = LAST_ADDR
) (
  input  logic                 clk,
  input  logic                 clear,
  output logic [P_ADDR_W-1:0]  imem_addr,
  input  logic [P_INSTR_W-1:0] imem_instr,
  input  logic                 redirect,
  input  logic [P_ADDR_W-1:0]  redirect_target,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [P_INSTR_W-1:0] out_instr,
  output logic [P_ADDR_W-1:0]  out_pc,
  output logic                 done
);

  localparam logic [P_ADDR_W-1:0] L_LAST = P_ADDR_W'(P_LAST_ADDR);

  fetch_state_t          r_state;
  logic [P_ADDR_W-1:0]   r_pc;
  logic                  r_valid;
  logic [P_INSTR_W-1:0]  r_instr;
  logic [P_ADDR_W-1:0]   r_out_pc;
  logic                  r_done;

  fetch_state_t          w_state_nxt;
  logic [P_ADDR_W-1:0]   w_pc_nxt;
  logic                  w_valid_nxt;
  logic [P_INSTR_W-1:0]  w_instr_nxt;
  logic [P_ADDR_W-1:0]   w_out_pc_nxt;
  logic                  w_issue;

  // Slot is free for a new word when empty or being drained this cycle.
  assign w_issue = (r_state == RUN) && (!r_valid || out_ready) && !redirect;

  // Next-state and datapath: redirect flushes, else issue, else drain on handshake.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_valid_nxt  = r_valid;
    w_instr_nxt  = r_instr;
    w_out_pc_nxt = r_out_pc;
    if (redirect) begin
      w_pc_nxt    = redirect_target;
      w_valid_nxt = 1'b0;
      w_state_nxt = (redirect_target <= L_LAST) ? RUN : DONE;
    end else if (w_issue) begin
      w_instr_nxt  = imem_instr;
      w_out_pc_nxt = r_pc;
      w_valid_nxt  = 1'b1;
      if (r_pc == L_LAST) begin
        w_state_nxt = DONE;
      end else begin
        w_pc_nxt = r_pc + P_ADDR_W'(1);
      end
    end else if (r_valid && out_ready) begin
      w_valid_nxt = 1'b0;
    end
  end

  // State register; done is precomputed so it leaves as a flop.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state  <= RUN;
      r_pc     <= '0;
      r_valid  <= 1'b0;
      r_instr  <= '0;
      r_out_pc <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_valid  <= w_valid_nxt;
      r_instr  <= w_instr_nxt;
      r_out_pc <= w_out_pc_nxt;
      r_done   <= (w_state_nxt == DONE) && !w_valid_nxt;
    end
  end

  assign imem_addr = r_pc;
  assign out_valid = r_valid;
  assign out_instr = r_instr;
  assign out_pc    = r_out_pc;
  assign done      = r_done;

endmodule : fetch_unit
